// File: rtl/kyogenrv_avl_arbiter.sv
// kyogenrv_avl_arbiter: round-robin two-master Avalon-MM arbiter with read-response timeout
module kyogenrv_avl_arbiter #(
  parameter int                 ADDR_W   = 32,
  parameter int                 DATA_W   = 32,
  parameter int                 TIMEOUT  = 255,
  parameter logic [DATA_W-1:0]  ERR_DATA = DATA_W'(32'hDEAD_BEEF)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   m0_address_i,
  input  logic                m0_read_i,
  input  logic                m0_write_i,
  input  logic [DATA_W-1:0]   m0_writedata_i,
  input  logic [DATA_W/8-1:0] m0_byteenable_i,
  output logic                m0_waitrequest_o,
  output logic [DATA_W-1:0]   m0_readdata_o,
  output logic                m0_readdatavalid_o,
  input  logic [ADDR_W-1:0]   m1_address_i,
  input  logic                m1_read_i,
  input  logic                m1_write_i,
  input  logic [DATA_W-1:0]   m1_writedata_i,
  input  logic [DATA_W/8-1:0] m1_byteenable_i,
  output logic                m1_waitrequest_o,
  output logic [DATA_W-1:0]   m1_readdata_o,
  output logic                m1_readdatavalid_o,
  output logic [ADDR_W-1:0]   s_address_o,
  output logic                s_read_o,
  output logic                s_write_o,
  output logic [DATA_W-1:0]   s_writedata_o,
  output logic [DATA_W/8-1:0] s_byteenable_o,
  input  logic                s_waitrequest_i,
  input  logic [DATA_W-1:0]   s_readdata_i,
  input  logic                s_readdatavalid_i,
  output logic                bus_err_o
);
  typedef enum logic [1:0] {IDLE, CMD, RESP} state_t;
  // Last counter value before the timeout strobe fires; RESP is entered with the counter at zero.
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  state_t      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_q, last_d;
  logic [15:0] cnt_q, cnt_d;
  logic        bus_err_q, bus_err_d;
  logic        g_read, g_write, accept, timeout, rsp_strobe;
  logic [DATA_W-1:0] rsp_data;
  assign g_read  = grant_q ? m1_read_i  : m0_read_i;
  assign g_write = grant_q ? m1_write_i : m0_write_i;
  assign accept  = (state_q == CMD) && !s_waitrequest_i;
  assign timeout = cnt_q >= TO_LAST;
  // State register, grant bookkeeping, timeout counter and sticky error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= 1'b0;
      last_q    <= 1'b1;
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end
  // Next state: arbitrate in IDLE, wait for acceptance in CMD, wait for data or timeout in RESP
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    bus_err_d = bus_err_q;
    case (state_q)
      IDLE: if (m0_read_i || m0_write_i || m1_read_i || m1_write_i) begin
        grant_d = ((m0_read_i || m0_write_i) && (m1_read_i || m1_write_i)) ? ~last_q : (m1_read_i || m1_write_i);
        state_d = CMD;
      end
      CMD: if (!s_waitrequest_i) begin
        last_d  = grant_q;
        cnt_d   = '0;
        state_d = g_read ? RESP : IDLE;
      end
      RESP: begin
        cnt_d = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        if (s_readdatavalid_i || timeout) state_d = IDLE;
        if (!s_readdatavalid_i && timeout) bus_err_d = 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end
  // Outputs: slave command muxed on the registered grant, response routed combinationally
  always_comb begin
    rsp_strobe         = (state_q == RESP) && (s_readdatavalid_i || timeout);
    rsp_data           = s_readdatavalid_i ? s_readdata_i : ERR_DATA;
    s_address_o        = grant_q ? m1_address_i    : m0_address_i;
    s_writedata_o      = grant_q ? m1_writedata_i  : m0_writedata_i;
    s_byteenable_o     = grant_q ? m1_byteenable_i : m0_byteenable_i;
    s_read_o           = (state_q == CMD) && g_read;
    s_write_o          = (state_q == CMD) && g_write;
    m0_waitrequest_o   = !(accept && !grant_q);
    m1_waitrequest_o   = !(accept && grant_q);
    m0_readdatavalid_o = rsp_strobe && !grant_q;
    m1_readdatavalid_o = rsp_strobe && grant_q;
    m0_readdata_o      = m0_readdatavalid_o ? rsp_data : '0;
    m1_readdata_o      = m1_readdatavalid_o ? rsp_data : '0;
    bus_err_o          = bus_err_q;
  end
endmodule

// File: tb/tb_kyogenrv_avl_arbiter.sv
// tb_kyogenrv_avl_arbiter: directed self-checking bench for the two-master Avalon arbiter
module tb_kyogenrv_avl_arbiter;
  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] m0_address, m1_address, m0_writedata, m1_writedata, m0_readdata, m1_readdata;
  logic [3:0]  m0_byteenable, m1_byteenable, s_byteenable;
  logic        m0_read, m0_write, m1_read, m1_write;
  logic        m0_wr, m1_wr, m0_rdv, m1_rdv;
  logic [31:0] s_address, s_writedata, s_readdata;
  logic        s_read, s_write, s_waitrequest, s_rdv, bus_err;
  int          errors = 0;
  int          checks = 0;

  always #5 clk = ~clk;

  kyogenrv_avl_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(8), .ERR_DATA(32'hDEAD_BEEF)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_address_i(m0_address), .m0_read_i(m0_read), .m0_write_i(m0_write),
    .m0_writedata_i(m0_writedata), .m0_byteenable_i(m0_byteenable),
    .m0_waitrequest_o(m0_wr), .m0_readdata_o(m0_readdata), .m0_readdatavalid_o(m0_rdv),
    .m1_address_i(m1_address), .m1_read_i(m1_read), .m1_write_i(m1_write),
    .m1_writedata_i(m1_writedata), .m1_byteenable_i(m1_byteenable),
    .m1_waitrequest_o(m1_wr), .m1_readdata_o(m1_readdata), .m1_readdatavalid_o(m1_rdv),
    .s_address_o(s_address), .s_read_o(s_read), .s_write_o(s_write),
    .s_writedata_o(s_writedata), .s_byteenable_o(s_byteenable),
    .s_waitrequest_i(s_waitrequest), .s_readdata_i(s_readdata), .s_readdatavalid_i(s_rdv),
    .bus_err_o(bus_err)
  );

  task automatic clear_inputs();
    {m0_read, m0_write, m1_read, m1_write} = '0;
    m0_address = '0; m1_address = '0; m0_writedata = '0; m1_writedata = '0;
    m0_byteenable = 4'hF; m1_byteenable = 4'hF;
    s_waitrequest = 1'b0; s_readdata = '0; s_rdv = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk); clear_inputs(); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear_inputs();
    @(negedge clk); #1;
    checks++; if ({m0_wr, m1_wr, s_read, s_write, m0_rdv, m1_rdv, bus_err} !== 7'b1100000) begin errors++; $display("FAIL reset_ctrl got=%b exp=1100000", {m0_wr, m1_wr, s_read, s_write, m0_rdv, m1_rdv, bus_err}); end
    checks++; if (m0_readdata !== 32'h0 || m1_readdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h/%h exp=0/0", m0_readdata, m1_readdata); end
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk); #1;
    checks++; if ({m0_wr, m1_wr, s_read, s_write, m0_rdv, m1_rdv, bus_err} !== 7'b1100000) begin errors++; $display("FAIL idle_ctrl got=%b exp=1100000", {m0_wr, m1_wr, s_read, s_write, m0_rdv, m1_rdv, bus_err}); end
  endtask

  task automatic test_single_write();
    @(negedge clk);
    m1_write = 1'b1; m1_address = 32'h10; m1_writedata = 32'hA5A5_0001; m1_byteenable = 4'hF; s_waitrequest = 1'b1;
    #1;
    checks++; if ({s_write, m1_wr} !== 2'b01) begin errors++; $display("FAIL wr_idle got=%b exp=01", {s_write, m1_wr}); end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk);
      if (c == 3) s_waitrequest = 1'b0;
      #1;
      checks++; if ({s_address, s_writedata, s_byteenable, s_write, s_read} !== {32'h10, 32'hA5A5_0001, 4'hF, 2'b10}) begin errors++; $display("FAIL wr_cmd%0d got=%h/%h/%h/%b%b exp=10/a5a50001/f/10", c, s_address, s_writedata, s_byteenable, s_write, s_read); end
      checks++; if ({m0_wr, m1_wr} !== {1'b1, c != 3}) begin errors++; $display("FAIL wr_wait%0d got=%b exp=%b", c, {m0_wr, m1_wr}, {1'b1, c != 3}); end
    end
    @(negedge clk); m1_write = 1'b0; #1;
    checks++; if ({s_write, m0_wr, m1_wr, m0_rdv} !== 4'b0110) begin errors++; $display("FAIL wr_done got=%b exp=0110", {s_write, m0_wr, m1_wr, m0_rdv}); end
  endtask

  task automatic test_simultaneous_reads();
    pulse_reset();
    @(negedge clk);
    m0_read = 1'b1; m0_address = 32'h100; m1_read = 1'b1; m1_address = 32'h200;
    @(negedge clk); #1;
    checks++; if ({s_read, s_address, m0_wr, m1_wr} !== {1'b1, 32'h100, 2'b01}) begin errors++; $display("FAIL rd0_cmd got=%b/%h/%b exp=1/100/01", s_read, s_address, {m0_wr, m1_wr}); end
    @(negedge clk); m0_read = 1'b0; #1;
    checks++; if ({s_read, m0_rdv, m1_rdv} !== 3'b000) begin errors++; $display("FAIL rd0_wait got=%b exp=000", {s_read, m0_rdv, m1_rdv}); end
    @(negedge clk); s_rdv = 1'b1; s_readdata = 32'h1111; #1;
    checks++; if ({m0_rdv, m1_rdv, m0_readdata} !== {2'b10, 32'h1111}) begin errors++; $display("FAIL rd0_resp got=%b/%h exp=10/1111", {m0_rdv, m1_rdv}, m0_readdata); end
    @(negedge clk); s_rdv = 1'b0; #1;
    checks++; if ({m0_rdv, m1_rdv, s_read} !== 3'b000) begin errors++; $display("FAIL rd_gap got=%b exp=000", {m0_rdv, m1_rdv, s_read}); end
    @(negedge clk); #1;
    checks++; if ({s_read, s_address, m0_wr, m1_wr} !== {1'b1, 32'h200, 2'b10}) begin errors++; $display("FAIL rd1_cmd got=%b/%h/%b exp=1/200/10", s_read, s_address, {m0_wr, m1_wr}); end
    @(negedge clk); m1_read = 1'b0;
    @(negedge clk); s_rdv = 1'b1; s_readdata = 32'h2222; #1;
    checks++; if ({m0_rdv, m1_rdv, m1_readdata} !== {2'b01, 32'h2222}) begin errors++; $display("FAIL rd1_resp got=%b/%h exp=01/2222", {m0_rdv, m1_rdv}, m1_readdata); end
    @(negedge clk); s_rdv = 1'b0;
  endtask

  task automatic test_round_robin();
    int n0 = 0, n1 = 0, idx = 0;
    pulse_reset();
    @(negedge clk);
    m0_write = 1'b1; m0_address = 32'hA0; m1_write = 1'b1; m1_address = 32'hB0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk); #1;
      if (!m0_wr || !m1_wr) begin
        checks++; if ({m0_wr, m1_wr} !== (idx % 2 == 0 ? 2'b01 : 2'b10)) begin errors++; $display("FAIL rr_order%0d got=%b exp=%b", idx, {m0_wr, m1_wr}, (idx % 2 == 0 ? 2'b01 : 2'b10)); end
        if (!m0_wr) n0++; else n1++;
        idx++;
      end
    end
    m0_write = 1'b0; m1_write = 1'b0;
    checks++; if (n0 != 5 || n1 != 5) begin errors++; $display("FAIL rr_count got=%0d/%0d exp=5/5", n0, n1); end
  endtask

  task automatic test_timeout();
    pulse_reset();
    @(negedge clk); m0_read = 1'b1; m0_address = 32'h300;
    @(negedge clk); #1;
    checks++; if ({s_read, m0_wr} !== 2'b10) begin errors++; $display("FAIL to_accept got=%b exp=10", {s_read, m0_wr}); end
    for (int k = 2; k <= 8; k++) begin
      @(negedge clk);
      if (k == 2) m0_read = 1'b0;
      #1;
      checks++; if ({m0_rdv, m1_rdv, bus_err} !== 3'b000) begin errors++; $display("FAIL to_wait%0d got=%b exp=000", k, {m0_rdv, m1_rdv, bus_err}); end
    end
    @(negedge clk); #1;
    checks++; if ({m0_rdv, m1_rdv, m0_readdata, bus_err} !== {2'b10, 32'hDEAD_BEEF, 1'b0}) begin errors++; $display("FAIL to_strobe got=%b/%h/%b exp=10/deadbeef/0", {m0_rdv, m1_rdv}, m0_readdata, bus_err); end
    @(negedge clk); m1_write = 1'b1; m1_address = 32'h20; m1_writedata = 32'h1234_5678; #1;
    checks++; if ({bus_err, m0_rdv} !== 2'b10) begin errors++; $display("FAIL to_err got=%b exp=10", {bus_err, m0_rdv}); end
    @(negedge clk); #1;
    checks++; if ({s_write, s_address, s_writedata, m1_wr} !== {1'b1, 32'h20, 32'h1234_5678, 1'b0}) begin errors++; $display("FAIL to_after_wr got=%b/%h/%h/%b exp=1/20/12345678/0", s_write, s_address, s_writedata, m1_wr); end
    @(negedge clk); m1_write = 1'b0; #1;
    checks++; if ({bus_err, s_write} !== 2'b10) begin errors++; $display("FAIL to_sticky got=%b exp=10", {bus_err, s_write}); end
  endtask

  task automatic test_reset_during_resp();
    @(negedge clk); m1_read = 1'b1; m1_address = 32'h40;
    @(negedge clk); #1;
    checks++; if ({s_read, m1_wr} !== 2'b10) begin errors++; $display("FAIL rr_rd_accept got=%b exp=10", {s_read, m1_wr}); end
    @(negedge clk); m1_read = 1'b0;
    @(negedge clk); rst_n = 1'b0; #1;
    checks++; if ({m0_wr, m1_wr, s_read, m0_rdv, m1_rdv, bus_err} !== 6'b110000) begin errors++; $display("FAIL rst_mid got=%b exp=110000", {m0_wr, m1_wr, s_read, m0_rdv, m1_rdv, bus_err}); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk); s_rdv = 1'b1; s_readdata = 32'h3333; #1;
    checks++; if ({m0_rdv, m1_rdv, bus_err} !== 3'b000 || m0_readdata !== 32'h0 || m1_readdata !== 32'h0) begin errors++; $display("FAIL stray got=%b/%h/%h exp=000/0/0", {m0_rdv, m1_rdv, bus_err}, m0_readdata, m1_readdata); end
    @(negedge clk); s_rdv = 1'b0; m0_write = 1'b1; m0_address = 32'h50; #1;
    checks++; if ({m0_wr, s_write} !== 2'b10) begin errors++; $display("FAIL post_rst_idle got=%b exp=10", {m0_wr, s_write}); end
    @(negedge clk); #1;
    checks++; if ({m0_wr, s_write, s_address} !== {2'b01, 32'h50}) begin errors++; $display("FAIL post_rst_wr got=%b/%h exp=01/50", {m0_wr, s_write}, s_address); end
    @(negedge clk); m0_write = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_simultaneous_reads();
    test_round_robin();
    test_timeout();
    test_reset_during_resp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/kyogenrv_avl_arbiter.md
# kyogenrv_avl_arbiter

Two-master, one-slave Avalon-MM arbiter that shares a single slave (on-chip RAM or PIO window) between the KyogenRV instruction-fetch master (m0) and data master (m1). It sits between the core and the slave in the clk_riscv domain and is driven by the synchronised reset (rst_n). Arbitration is round-robin, with at most one outstanding transaction. A read-response timeout guarantees forward progress if the slave never answers.

## Interface
- ADDR_W, 32, address width for both masters and the slave
- DATA_W, 32, data width; byteenable width is DATA_W/8
- TIMEOUT, 255, maximum cycles to wait for s_readdatavalid (range 1..65535)
- ERR_DATA, 32'hDEAD_BEEF, readdata returned on timeout
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- mN_address / mN_read / mN_write / mN_writedata / mN_byteenable  in  ADDR_W/1/1/DATA_W/DATA_W/8  master N command (N = 0, 1)
- mN_waitrequest  out  1  master N stall
- mN_readdata  out  DATA_W  read data to master N
- mN_readdatavalid  out  1  read response strobe to master N
- s_address / s_read / s_write / s_writedata / s_byteenable  out  ADDR_W/1/1/DATA_W/DATA_W/8  slave command
- s_waitrequest  in  1  slave stall
- s_readdata  in  DATA_W  slave read data
- s_readdatavalid  in  1  slave read response
- bus_err  out  1  sticky timeout flag; cleared only by reset

## Operation
- FSM states: IDLE, CMD, RESP.
- IDLE:
  - Request: reqN = mN_read | mN_write.
  - With one request, register grant = that master and go to CMD.
  - With both requests, grant goes to the master that was not granted last (round-robin).
  - last_grant resets to 1, so m0 wins the first tie.
- CMD:
  - s_* = granted master's command (combinational mux on the registered grant).
  - Command stays asserted while s_waitrequest = 1.
  - In the cycle s_waitrequest = 0, the command is accepted.
    - Write accepted: go to IDLE and update last_grant.
    - Read accepted: go to RESP, clear the timeout counter, and update last_grant.
- RESP:
  - s_read = s_write = 0.
  - On s_readdatavalid: route s_readdata to the granted master's readdata and pulse its readdatavalid for 1 cycle, then go to IDLE.
  - If the counter reaches TIMEOUT first: pulse readdatavalid with readdata = ERR_DATA, set bus_err, then go to IDLE.
  - The counter is 16 bits and saturates; it never wraps.
- mN_waitrequest:
  - 0 only in the cycle where state = CMD, grant = N and s_waitrequest = 0.
  - 1 otherwise, including idle and while the other master is served.
- s_readdatavalid outside RESP (stray response) is ignored; no master strobe is generated.
- A master that drops its request while stalled violates Avalon; behaviour is undefined and need not be checked.
- Reset mid-transaction returns the arbiter to IDLE immediately; any in-flight slave response after reset is dropped as stray.
- Reset values:
  - State = IDLE, grant = 0, last_grant = 1, counter = 0, bus_err = 0.
  - s_read = s_write = 0.
  - mN_waitrequest = 1, mN_readdatavalid = 0, mN_readdata = 0.

## Timing
- Request seen in IDLE at cycle N drives the slave command from cycle N+1. With a zero-wait slave, the master's waitrequest is low in N+1.
- Write with zero-wait slave: 2 cycles from request to acceptance; the next arbitration starts in N+2.
- Read with slave latency L (readdatavalid L cycles after acceptance): master readdatavalid is in the same cycle as s_readdatavalid (combinational route). The arbiter is back in IDLE the cycle after.
- Timeout: ERR_DATA strobe occurs TIMEOUT cycles after read acceptance; bus_err is high from the next cycle on.
- Back-to-back requests from both masters alternate grants: m0, m1, m0, ...
- No pipelining; throughput is at most 1 transaction per 2 cycles.

## Test plan
- Reset then idle: all outputs hold their reset values; m0_waitrequest = m1_waitrequest = 1; s_read = 0.
- Single m1 write:
  - Stimulus: m1 writes addr 0x10, data 0xA5A5_0001, byteenable 0xF; slave s_waitrequest = 1 for 2 cycles, then 0.
  - Response: s_* equals m1's command for 3 cycles; m1_waitrequest is low only in the third; m0 is untouched.
- Simultaneous reads:
  - Stimulus: m0 and m1 both read from reset; slave returns 0x1111 then 0x2222 with L = 2.
  - Response: m0 is granted first and gets 0x1111, then m1 gets 0x2222; readdatavalid is never asserted on the wrong master.
- Round-robin fairness: both masters request continuously for 10 transactions -> grants alternate exactly 5/5, starting with m0.
- Timeout:
  - Stimulus: TIMEOUT = 8; m0 reads and the slave never responds.
  - Response: m0_readdatavalid pulses with 0xDEAD_BEEF 8 cycles after acceptance; bus_err = 1 sticky; a subsequent m1 write completes normally.
- Reset during RESP: assert rst_n low mid-read, then release and inject a stray s_readdatavalid -> no master strobe; bus_err = 0; state is IDLE.
